// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : 4-digit multiplexed 7-segment driver with zero blanking and sign.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       negative,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int             CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]     C_BLANK   = 7'b1111111;
    localparam logic [6:0]     C_MINUS   = 7'b0111111;

    logic [CNT_W-1:0] r_presc;
    logic [1:0]       r_idx;
    logic [3:0]       r_ones, r_tens, r_hund;
    logic             r_neg;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame;

    logic             w_tick;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [1:0]       w_idx_nxt;
    logic [3:0]       w_ones_nxt, w_tens_nxt, w_hund_nxt;
    logic             w_neg_nxt;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1000000;
            4'd1:    f_decode = 7'b1111001;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            default: f_decode = 7'b0000110;
        endcase
    endfunction

    // Outputs are registered from next-state values so a new index or a new
    // load shows up exactly one cycle after the edge that caused it.
    always_comb begin
        w_tick      = (r_presc == C_CNT_MAX);
        w_presc_nxt = w_tick ? '0 : r_presc + CNT_W'(1);
        w_idx_nxt   = w_tick ? r_idx + 2'd1 : r_idx;
        w_ones_nxt  = load ? ones     : r_ones;
        w_tens_nxt  = load ? tens     : r_tens;
        w_hund_nxt  = load ? hundreds : r_hund;
        w_neg_nxt   = load ? negative : r_neg;
        w_an_nxt    = ~(4'b0001 << w_idx_nxt);
        w_seg_nxt   = C_BLANK;
        case (w_idx_nxt)
            2'd0: w_seg_nxt = f_decode(w_ones_nxt);
            2'd1: w_seg_nxt = ((w_hund_nxt == 4'd0) && (w_tens_nxt == 4'd0)) ?
                              C_BLANK : f_decode(w_tens_nxt);
            2'd2: w_seg_nxt = (w_hund_nxt == 4'd0) ? C_BLANK : f_decode(w_hund_nxt);
            default: w_seg_nxt = w_neg_nxt ? C_MINUS : C_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_hund  <= 4'd0;
            r_neg   <= 1'b0;
            r_an    <= 4'b1111;
            r_seg   <= C_BLANK;
            r_frame <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_hund  <= w_hund_nxt;
            r_neg   <= w_neg_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_frame <= w_tick && (r_idx == 2'd3);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = 1'b1;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  when high at a clk edge, captures ones/tens/hundreds/negative into shadow registers.
REQ-005 SHALL have port ones  input  4  BCD units digit from the binary-to-BCD stage.
REQ-006 SHALL have port tens  input  4  BCD tens digit.
REQ-007 SHALL have port hundreds  input  4  BCD hundreds digit.
REQ-008 SHALL have port negative  input  1  when 1, the leftmost digit shows a minus sign.
REQ-009 SHALL have port an  output  4  active-low digit enables; an[0] is the rightmost digit.
REQ-010 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp  output  1  active-low decimal point, held at 1 (off) at all times.
REQ-012 SHALL have port frame  output  1  one-cycle pulse each time the scan wraps from digit 3 to digit 0.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle count==REFRESH_DIV-1.
REQ-014 A 2-bit digit index SHALL advance on tick: 0->1->2->3->0.
REQ-015 frame SHALL be high for exactly the one cycle after the tick that advances the index from 3 to 0.
REQ-016 Shadow registers SHALL update only on a load edge; input changes without load SHALL NOT affect the display.
REQ-017 an and seg SHALL be registered: in the cycle after any edge that changes the index or the shadows, they reflect the new state (one-cycle latency).
REQ-018 an SHALL be one-hot-low for index i: 0->1110, 1->1101, 2->1011, 3->0111; exactly one digit is enabled outside reset.
REQ-019 Index 0 SHALL show shadow ones; it is never blanked.
REQ-020 Index 1 SHALL show shadow tens, blanked when shadow hundreds==0 and tens==0.
REQ-021 Index 2 SHALL show shadow hundreds, blanked when hundreds==0.
REQ-022 Index 3 SHALL show minus (0111111) when shadow negative==1, otherwise blank (1111111).
REQ-023 Decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Digit codes 10..15 SHALL display E (0000110) and SHALL NOT participate in blanking as zero.
REQ-025 Simultaneous load and tick SHALL both take effect: the next output shows the new index with the new shadow data.
REQ-026 load held high for multiple cycles SHALL recapture every cycle; no other effect.

Reset
REQ-027 While reset is high: prescaler=0, index=0, shadows=0, negative shadow=0, an=1111, seg=1111111, dp=1, frame=0, regardless of clk.
REQ-028 Reset assertion mid-scan SHALL force the reset values immediately, without waiting for a clk edge.
REQ-029 On the first clk edge after reset deasserts, the outputs SHALL become an=1110, seg=1000000 (ones digit showing 0); the prescaler starts from 0.

Verification (REFRESH_DIV=4)
REQ-030 Reset, release, run 16 cycles -> an sequence 1110,1101,1011,0111 at 4-cycle intervals; seg 1000000 on an=1110, 1111111 elsewhere; one frame pulse.
REQ-031 load with hundreds=2, tens=3, ones=9, negative=0 -> digits 0..2 show 0010000, 0110000, 0100100; digit 3 blank.
REQ-032 load 0,0,7 with negative=1 -> digit 0 shows 1111000; digits 1,2 blank; digit 3 shows 0111111.
REQ-033 load 1,0,5 -> tens shows 1000000 (not blanked), hundreds shows 1111001; then change inputs without load -> display unchanged.
REQ-034 load ones=4'hC -> digit 0 shows 0000110; load asserted on the tick cycle -> next digit shows the new value.
REQ-035 Assert reset mid-scan while an=1011 -> an=1111, seg=1111111 asynchronously; after release, the scan restarts at an=1110.
